apb_slave_regfile: RTL



---
 rtl/apb_slave_regfile.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer holding a bank of DATA_W-bit registers.
// Each transfer is SETUP, then 1+WAIT_STATES ACCESS cycles. pready is
// registered, so with zero wait states it is already high in the first
// ACCESS cycle. Addresses at or above NUM_REGS drop writes and read as 0.
// Optional feature macro: APB_SLAVE_PSLVERR_EN. When it is defined, an
// out-of-range access raises pslverr alongside pready. When it is not
// defined, pslverr is tied low.
module apb_slave_regfile #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              pwrite,
   input  logic              psel,
   input  logic              penable,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_write;
   logic [3:0]        r_cnt;
   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [DATA_W-1:0] r_prdata;
   logic              r_pready;

   logic              w_setup;
   logic              w_access;
   logic [ADDR_W-1:0] w_addr;
   logic              w_is_rd;
   logic              w_in_rng;
   logic [DATA_W-1:0] w_rdata;
   logic              w_enter_rdy;
   logic              w_leave_rdy;

   assign w_setup  = psel & ~penable;
   assign w_access = psel & penable;

   // When jumping straight from IDLE to READY the address and direction are
   // still on the bus, not yet latched, so take them from the bus in IDLE.
   assign w_addr   = (r_state == S_IDLE) ? paddr : r_addr;
   assign w_is_rd  = (r_state == S_IDLE) ? ~pwrite : ~r_write;
   assign w_in_rng = 32'(w_addr) < 32'(NUM_REGS);
   assign w_rdata  = w_in_rng ? r_regs[w_addr] : '0;

   assign w_enter_rdy = ((r_state == S_IDLE) && w_setup && (WAIT_STATES == 0)) ||
                        ((r_state == S_WAIT) && w_access && (r_cnt == 4'd1));
   // Leaving READY either completes the transfer or aborts it when psel drops.
   assign w_leave_rdy = (r_state == S_READY) && (w_access || !psel);

   // Transfer FSM, register bank and registered response outputs.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_write  <= 1'b0;
         r_cnt    <= '0;
         r_prdata <= '0;
         r_pready <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_setup) begin
                  r_addr  <= paddr;
                  r_write <= pwrite;
                  r_cnt   <= 4'(WAIT_STATES);
                  r_state <= (WAIT_STATES == 0) ? S_READY : S_WAIT;
               end
            end
            S_WAIT: begin
               if (!psel) begin
                  r_state <= S_IDLE;
               end else if (penable) begin
                  r_cnt <= r_cnt - 4'd1;
                  if (r_cnt == 4'd1) begin
                     r_state <= S_READY;
                  end
               end
            end
            S_READY: begin
               if (!psel) begin
                  r_state <= S_IDLE;
               end else if (penable) begin
                  // pwdata is taken on the completion edge, not at SETUP.
                  if (r_write && w_in_rng) begin
                     r_regs[r_addr] <= pwdata;
                  end
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_enter_rdy) begin
            r_pready <= 1'b1;
            if (w_is_rd) begin
               r_prdata <= w_rdata;
            end
         end else if (w_leave_rdy) begin
            r_pready <= 1'b0;
         end
      end
   end

`ifdef APB_SLAVE_PSLVERR_EN
   logic r_pslverr;

   // Error flag rises with pready for out-of-range addresses, clears with it.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_pslverr <= 1'b0;
      end else if (w_enter_rdy) begin
         r_pslverr <= ~w_in_rng;
      end else if (w_leave_rdy) begin
         r_pslverr <= 1'b0;
      end
   end

   assign pslverr = r_pslverr;
`else
   assign pslverr = 1'b0;
`endif

   assign prdata = r_prdata;
   assign pready = r_pready;

endmodule
